hazard_stall_controller: RTL and testbench
==========================================

// Module: hazard_stall_controller
// PURPOSE
//  Sequences pipeline stalls, bubbles and flushes for the 5-stage core; companion to Forward_Unit.
//  Detects hazards that forwarding alone cannot cover:
//    - load-use hazards;
//    - branches resolved in ID whose operands are not yet forwardable;
//    - external memory wait.
//  Drives PC / IF-ID write enables, ID-EX bubble insertion and the IF-ID flush on a taken branch.
//  Holds saturating stall/flush counters for performance readout.
// PARAMETERS
//  REG_W  5   register-address width
//  CNT_W  16  width of each performance counter (saturating)
// PORTS
//  clk             in   1      clock, rising edge
//  rst_n           in   1      asynchronous active-low reset
//  IfId_Rs         in   REG_W  source Rs of instruction in ID
//  IfId_Rt         in   REG_W  source Rt of instruction in ID
//  IfId_UsesRt     in   1      ID instruction reads Rt (R-type, beq, sw)
//  Ctrl_Branch     in   1      ID instruction is a branch
//  Branch_Taken    in   1      branch comparison result in ID (valid when Ctrl_Branch)
//  IdEx_Rd         in   REG_W  destination of EX instruction (already muxed Rt/Rd)
//  IdEx_MemRead    in   1      EX instruction is a load
//  IdEx_RegWr      in   1      EX instruction writes the register file
//  ExMem_Rd        in   REG_W  destination of MEM instruction
//  ExMem_MemRead   in   1      MEM instruction is a load
//  Mem_Ready       in   1      data memory ready; 0 = freeze whole pipeline
//  PcWrite         out  1      PC update enable
//  IfIdWrite       out  1      IF/ID register load enable
//  IdEx_Bubble     out  1      zero ID/EX control fields this cycle
//  IfId_Flush      out  1      clear IF/ID at next edge (squash fetched instruction)
//  Freeze          out  1      hold EX/MEM and MEM/WB (memory wait)
//  Stall_Count     out  CNT_W  cycles with IdEx_Bubble=1
//  Flush_Count     out  CNT_W  cycles with IfId_Flush=1
// BEHAVIOUR
//  Hazard terms (combinational). A register match requires Rd != 0.
//    ldu = IdEx_MemRead & (IdEx_Rd==IfId_Rs | IfId_UsesRt & IdEx_Rd==IfId_Rt)
//    bra = Ctrl_Branch & IdEx_RegWr & ~IdEx_MemRead & match(IdEx_Rd)   -> 1-cycle stall
//    brl = Ctrl_Branch & ldu                                           -> 2-cycle stall
//    brm = Ctrl_Branch & ExMem_MemRead & match(ExMem_Rd)               -> 1-cycle stall
//    haz = ldu | bra | brm
//  FSM states: RUN, HOLD (extra cycle for brl), WAIT (memory freeze).
//  Outputs are Mealy: a function of state and current inputs.
//  Priority within any state: Mem_Ready=0 > HOLD > haz > taken branch.
//  RUN:
//    - Mem_Ready=0: Freeze=1, PcWrite=0, IfIdWrite=0, IdEx_Bubble=0; -> WAIT.
//    - Otherwise, haz: PcWrite=0, IfIdWrite=0, IdEx_Bubble=1, IfId_Flush=0.
//      Next state is HOLD if brl, else RUN.
//    - Otherwise, Ctrl_Branch & Branch_Taken: IfId_Flush=1, PcWrite=1, IfIdWrite=1; stay RUN.
//    - Otherwise: PcWrite=1, IfIdWrite=1, all else 0.
//  HOLD: unconditional second stall cycle (same outputs as a haz cycle); -> RUN.
//  WAIT:
//    - Outputs as a freeze cycle while Mem_Ready=0.
//    - On Mem_Ready=1, resume into RUN evaluation in the same cycle (no dead cycle).
//    - Mem_Ready=0 in HOLD: freeze wins; HOLD is resumed after WAIT via a saved hold_pend bit.
//  A taken branch while stalled is never flushed early; IF/ID is frozen, so it re-resolves next cycle.
//  Latency: hazard-to-stall is 0 cycles (same cycle); flush takes effect at the next edge.
//  Counters increment at the edge after an asserting cycle, saturate at all-ones, never wrap.
//  Reset (rst_n=0, asynchronous):
//    - state=RUN, hold_pend=0, both counters=0;
//    - outputs forced PcWrite=0, IfIdWrite=0, IdEx_Bubble=1, IfId_Flush=0, Freeze=0.
//    - Reset mid-stall abandons HOLD/WAIT with no residual stall after release.
// TESTING
//  1. Load-use: IdEx_MemRead=1, IdEx_Rd=5'b11011, IfId_Rs=5'b11011
//     -> one cycle PcWrite=0, IdEx_Bubble=1; then RUN, Stall_Count=1.
//  2. Branch on load: Ctrl_Branch=1, IdEx_MemRead=1, IdEx_Rd=IfId_Rt=5'b11000, IfId_UsesRt=1
//     -> exactly 2 bubble cycles (RUN->HOLD->RUN).
//  3. Branch on ALU: Ctrl_Branch=1, IdEx_RegWr=1, IdEx_Rd=IfId_Rs=5'b00101
//     -> 1 stall; next cycle Branch_Taken=1 -> IfId_Flush=1, Flush_Count=1.
//  4. Rd=0: IdEx_MemRead=1, IdEx_Rd=0, IfId_Rs=0 -> no stall, PcWrite=1.
//  5. Mem_Ready=0 for 3 cycles during HOLD -> Freeze=1 for 3 cycles, then the remaining HOLD bubble.
//  6. Saturation and reset: force Stall_Count to 16'hFFFF, stall again -> stays FFFF.
//     Pulse rst_n low mid-HOLD -> counters 0 and RUN, asynchronously.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard sequencer: stalls for load-use and branch-operand hazards,
// freezes on memory wait, and flushes IF/ID on taken branches; counts stalls/flushes.
module hazard_stall_controller #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] IfId_Rs,
    input  logic [REG_W-1:0] IfId_Rt,
    input  logic             IfId_UsesRt,
    input  logic             Ctrl_Branch,
    input  logic             Branch_Taken,
    input  logic [REG_W-1:0] IdEx_Rd,
    input  logic             IdEx_MemRead,
    input  logic             IdEx_RegWr,
    input  logic [REG_W-1:0] ExMem_Rd,
    input  logic             ExMem_MemRead,
    input  logic             Mem_Ready,
    output logic             PcWrite,
    output logic             IfIdWrite,
    output logic             IdEx_Bubble,
    output logic             IfId_Flush,
    output logic             Freeze,
    output logic [CNT_W-1:0] Stall_Count,
    output logic [CNT_W-1:0] Flush_Count
);

    typedef enum logic [1:0] {RUN, HOLD, WAIT} state_t;

    state_t state, nextState;
    logic   holdPend, nextHoldPend;
    logic   idExMatch, exMemMatch;
    logic   ldu, bra, brl, brm, haz;
    logic   doHold;

    // Register 0 is hardwired, so a write to it never creates a dependency.
    assign idExMatch  = (IdEx_Rd != '0) &&
                        ((IdEx_Rd == IfId_Rs) || (IfId_UsesRt && (IdEx_Rd == IfId_Rt)));
    assign exMemMatch = (ExMem_Rd != '0) &&
                        ((ExMem_Rd == IfId_Rs) || (IfId_UsesRt && (ExMem_Rd == IfId_Rt)));

    assign ldu = IdEx_MemRead & idExMatch;
    assign bra = Ctrl_Branch & IdEx_RegWr & ~IdEx_MemRead & idExMatch;
    assign brl = Ctrl_Branch & ldu;
    assign brm = Ctrl_Branch & ExMem_MemRead & exMemMatch;
    assign haz = ldu | bra | brm;

    // A HOLD interrupted by a memory wait is resumed once the wait ends.
    assign doHold = (state == HOLD) || ((state == WAIT) && holdPend);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            holdPend <= 1'b0;
        end else begin
            state    <= nextState;
            holdPend <= nextHoldPend;
        end
    end

    always_comb begin
        nextState    = state;
        nextHoldPend = 1'b0;
        PcWrite      = 1'b0;
        IfIdWrite    = 1'b0;
        IdEx_Bubble  = 1'b0;
        IfId_Flush   = 1'b0;
        Freeze       = 1'b0;
        if (!rst_n) begin
            IdEx_Bubble = 1'b1;
            nextState   = RUN;
        end else if (!Mem_Ready) begin
            Freeze       = 1'b1;
            nextState    = WAIT;
            nextHoldPend = doHold;
        end else if (doHold) begin
            IdEx_Bubble = 1'b1;
            nextState   = RUN;
        end else if (haz) begin
            IdEx_Bubble = 1'b1;
            nextState   = brl ? HOLD : RUN;
        end else if (Ctrl_Branch && Branch_Taken) begin
            IfId_Flush = 1'b1;
            PcWrite    = 1'b1;
            IfIdWrite  = 1'b1;
            nextState  = RUN;
        end else begin
            PcWrite   = 1'b1;
            IfIdWrite = 1'b1;
            nextState = RUN;
        end
    end

    // Performance counters saturate at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Stall_Count <= '0;
            Flush_Count <= '0;
        end else begin
            if (IdEx_Bubble && (Stall_Count != '1))
                Stall_Count <= Stall_Count + CNT_W'(1);
            if (IfId_Flush && (Flush_Count != '1))
                Flush_Count <= Flush_Count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: directed scenarios with literal pins, then
// randomized traffic checked every cycle against a priority-rule reference model.
module tb_hazard_stall_controller;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       usesRt;
        logic       branch;
        logic       taken;
        logic [4:0] idExRd;
        logic       idExMemRead;
        logic       idExRegWr;
        logic [4:0] exMemRd;
        logic       exMemMemRead;
        logic       memReady;
        logic       rstN;
    } stim_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs, rt, idExRd, exMemRd;
    logic       usesRt, branch, taken, idExMemRead, idExRegWr, exMemMemRead, memReady;
    logic       pcWrite, ifIdWrite, bubble, flush, freeze;
    logic [15:0] stallCount, flushCount;
    logic       sPcWrite, sIfIdWrite, sBubble, sFlush, sFreeze;
    logic [2:0] sStallCount, sFlushCount;

    int errors = 0;
    int checks = 0;

    // Reference state: an owed second bubble plus ideal saturating counts.
    bit owe = 0;
    int stallCnt = 0, flushCnt = 0, sStallCnt = 0, sFlushCnt = 0;

    always #5 clk = ~clk;

    hazard_stall_controller #(.REG_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .IfId_Rs(rs), .IfId_Rt(rt), .IfId_UsesRt(usesRt),
        .Ctrl_Branch(branch), .Branch_Taken(taken), .IdEx_Rd(idExRd),
        .IdEx_MemRead(idExMemRead), .IdEx_RegWr(idExRegWr), .ExMem_Rd(exMemRd),
        .ExMem_MemRead(exMemMemRead), .Mem_Ready(memReady), .PcWrite(pcWrite),
        .IfIdWrite(ifIdWrite), .IdEx_Bubble(bubble), .IfId_Flush(flush), .Freeze(freeze),
        .Stall_Count(stallCount), .Flush_Count(flushCount)
    );

    // Narrow-counter copy sharing the same inputs so saturation is reached quickly.
    hazard_stall_controller #(.REG_W(5), .CNT_W(3)) dutSmall (
        .clk(clk), .rst_n(rst_n), .IfId_Rs(rs), .IfId_Rt(rt), .IfId_UsesRt(usesRt),
        .Ctrl_Branch(branch), .Branch_Taken(taken), .IdEx_Rd(idExRd),
        .IdEx_MemRead(idExMemRead), .IdEx_RegWr(idExRegWr), .ExMem_Rd(exMemRd),
        .ExMem_MemRead(exMemMemRead), .Mem_Ready(memReady), .PcWrite(sPcWrite),
        .IfIdWrite(sIfIdWrite), .IdEx_Bubble(sBubble), .IfId_Flush(sFlush), .Freeze(sFreeze),
        .Stall_Count(sStallCount), .Flush_Count(sFlushCount)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s = '0;
        s.memReady = 1'b1;
        s.rstN     = 1'b1;
        return s;
    endfunction

    task automatic applyStimulus(input stim_t s);
        rs = s.rs; rt = s.rt; usesRt = s.usesRt; branch = s.branch; taken = s.taken;
        idExRd = s.idExRd; idExMemRead = s.idExMemRead; idExRegWr = s.idExRegWr;
        exMemRd = s.exMemRd; exMemMemRead = s.exMemMemRead; memReady = s.memReady;
        rst_n = s.rstN;
    endtask

    function automatic bit depends(input stim_t s, input logic [4:0] rd);
        return (rd != 0) && ((rd == s.rs) || (s.usesRt && (rd == s.rt)));
    endfunction

    // Compare both instances against the rule-level model, then advance the model.
    task automatic checkOutput(input stim_t s);
        bit ldu, bra, brm, expPc, expIfId, expBub, expFl, expFr;
        ldu = s.idExMemRead && depends(s, s.idExRd);
        bra = s.branch && s.idExRegWr && !s.idExMemRead && depends(s, s.idExRd);
        brm = s.branch && s.exMemMemRead && depends(s, s.exMemRd);
        {expPc, expIfId, expBub, expFl, expFr} = '0;
        if (!s.rstN) begin
            expBub = 1; owe = 0;
            stallCnt = 0; flushCnt = 0; sStallCnt = 0; sFlushCnt = 0;
        end else if (!s.memReady) begin
            expFr = 1;
        end else if (owe) begin
            expBub = 1; owe = 0;
        end else if (ldu || bra || brm) begin
            expBub = 1; owe = s.branch && ldu;
        end else if (s.branch && s.taken) begin
            expFl = 1; expPc = 1; expIfId = 1;
        end else begin
            expPc = 1; expIfId = 1;
        end
        check("PcWrite", int'(pcWrite), int'(expPc));
        check("IfIdWrite", int'(ifIdWrite), int'(expIfId));
        check("IdEx_Bubble", int'(bubble), int'(expBub));
        check("IfId_Flush", int'(flush), int'(expFl));
        check("Freeze", int'(freeze), int'(expFr));
        check("Stall_Count", int'(stallCount), stallCnt);
        check("Flush_Count", int'(flushCount), flushCnt);
        check("small Stall_Count", int'(sStallCount), sStallCnt);
        check("small Flush_Count", int'(sFlushCount), sFlushCnt);
        check("small Bubble", int'(sBubble), int'(expBub));
        if (s.rstN) begin
            if (expBub) begin
                if (stallCnt < 65535) stallCnt++;
                if (sStallCnt < 7) sStallCnt++;
            end
            if (expFl) begin
                if (flushCnt < 65535) flushCnt++;
                if (sFlushCnt < 7) sFlushCnt++;
            end
        end
    endtask

    task automatic runCycle(input stim_t s);
        @(posedge clk);
        #1 applyStimulus(s);
        @(negedge clk);
        checkOutput(s);
    endtask

    task automatic doReset();
        stim_t s = idle();
        s.rstN = 1'b0;
        runCycle(s);
        runCycle(idle());
    endtask

    initial begin
        stim_t s;
        applyStimulus(idle());
        rst_n = 1'b0;
        #2;
        check("reset PcWrite", int'(pcWrite), 0);
        check("reset Bubble", int'(bubble), 1);
        doReset();

        // Load-use on Rs
        s = idle(); s.idExMemRead = 1; s.idExRd = 5'b11011; s.rs = 5'b11011;
        runCycle(s);
        check("ldu PcWrite", int'(pcWrite), 0);
        check("ldu Bubble", int'(bubble), 1);
        runCycle(idle());
        check("ldu after PcWrite", int'(pcWrite), 1);
        check("ldu Stall_Count", int'(stallCount), 1);

        // Branch depending on a load: two bubbles
        doReset();
        s = idle(); s.branch = 1; s.idExMemRead = 1; s.idExRd = 5'b11000;
        s.rt = 5'b11000; s.usesRt = 1;
        runCycle(s);
        check("brl bubble 1", int'(bubble), 1);
        s = idle(); s.branch = 1; s.rt = 5'b11000; s.usesRt = 1;
        runCycle(s);
        check("brl bubble 2", int'(bubble), 1);
        runCycle(idle());
        check("brl done", int'(bubble), 0);
        check("brl Stall_Count", int'(stallCount), 2);

        // Branch on ALU result, then taken flush
        doReset();
        s = idle(); s.branch = 1; s.idExRegWr = 1; s.idExRd = 5'b00101; s.rs = 5'b00101;
        runCycle(s);
        check("bra bubble", int'(bubble), 1);
        s = idle(); s.branch = 1; s.taken = 1; s.rs = 5'b00101;
        runCycle(s);
        check("taken flush", int'(flush), 1);
        runCycle(idle());
        check("Flush_Count", int'(flushCount), 1);

        // Rd = 0 never matches
        s = idle(); s.idExMemRead = 1;
        runCycle(s);
        check("rd0 PcWrite", int'(pcWrite), 1);

        // Memory wait during HOLD
        doReset();
        s = idle(); s.branch = 1; s.idExMemRead = 1; s.idExRd = 5'd9; s.rs = 5'd9;
        runCycle(s);
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.memReady = 0;
            runCycle(s);
            check("wait Freeze", int'(freeze), 1);
        end
        runCycle(idle());
        check("resumed HOLD bubble", int'(bubble), 1);
        runCycle(idle());
        check("after HOLD PcWrite", int'(pcWrite), 1);

        // Saturation of the narrow counters
        doReset();
        s = idle(); s.idExMemRead = 1; s.idExRd = 5'd3; s.rs = 5'd3;
        for (int i = 0; i < 10; i++) runCycle(s);
        runCycle(idle());
        check("small saturated", int'(sStallCount), 7);
        check("wide count 10", int'(stallCount), 10);

        // Asynchronous reset in the middle of HOLD
        s = idle(); s.branch = 1; s.idExMemRead = 1; s.idExRd = 5'd7; s.rt = 5'd7; s.usesRt = 1;
        runCycle(s);
        @(posedge clk);
        #1 applyStimulus(idle());
        #2 rst_n = 1'b0;
        #1;
        check("async Stall_Count", int'(stallCount), 0);
        check("async Bubble", int'(bubble), 1);
        check("async PcWrite", int'(pcWrite), 0);
        owe = 0; stallCnt = 0; flushCnt = 0; sStallCnt = 0; sFlushCnt = 0;
        runCycle(idle());
        check("no residual HOLD", int'(bubble), 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            s.rs           = 5'($urandom_range(0, 3));
            s.rt           = 5'($urandom_range(0, 3));
            s.idExRd       = 5'($urandom_range(0, 3));
            s.exMemRd      = 5'($urandom_range(0, 3));
            s.usesRt       = 1'($urandom_range(0, 1));
            s.branch       = 1'($urandom_range(0, 1));
            s.taken        = 1'($urandom_range(0, 1));
            s.idExMemRead  = 1'($urandom_range(0, 1));
            s.idExRegWr    = 1'($urandom_range(0, 1));
            s.exMemMemRead = 1'($urandom_range(0, 1));
            s.memReady     = ($urandom_range(0, 5) != 0);
            s.rstN         = ($urandom_range(0, 99) != 0);
            runCycle(s);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
